// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, data width and default oversampling.
package uart_pkg;

    localparam int unsigned UART_DATA_W     = 8;
    localparam int unsigned UART_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter: first-word-fall-through, one wrap bit per pointer.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = UART_DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, paced by a synchronised 16x-baud strobe and fed from a byte FIFO.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tx_clk,
    input  logic                   enabled,
    input  logic [UART_DATA_W-1:0] data,
    input  logic                   valid,
    output logic                   ready,
    output logic                   tx,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned     TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]   TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]      BIT_LAST  = 3'd7;

    logic tx_clk_meta;
    logic tx_clk_sync;
    logic tx_clk_prev;
    logic tick;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [UART_DATA_W-1:0] fifo_dout;
    logic                   push;
    logic                   pop;

    uart_state_t            state;
    uart_state_t            state_next;
    logic [TW-1:0]          tick_cnt;
    logic [TW-1:0]          tick_cnt_next;
    logic [2:0]             bit_cnt;
    logic [2:0]             bit_cnt_next;
    logic [UART_DATA_W-1:0] sr;
    logic [UART_DATA_W-1:0] sr_next;
    logic                   bit_end;
    logic                   frame_end;

    logic tx_next;
    logic busy_next;
    logic done_next;

    // Registered edge detect puts tick three clk after the tx_clk rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_clk_meta <= 1'b0;
            tx_clk_sync <= 1'b0;
            tx_clk_prev <= 1'b0;
            tick        <= 1'b0;
        end else begin
            tx_clk_meta <= tx_clk;
            tx_clk_sync <= tx_clk_meta;
            tx_clk_prev <= tx_clk_sync;
            tick        <= tx_clk_sync && !tx_clk_prev;
        end
    end

    assign ready = !fifo_full;
    assign push  = valid && ready;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            sr       <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_cnt_next;
            bit_cnt  <= bit_cnt_next;
            sr       <= sr_next;
            tx       <= tx_next;
            busy     <= busy_next;
            done     <= done_next;
        end
    end

    assign bit_end = tick && (tick_cnt == TICK_LAST);

    always_comb begin
        state_next    = state;
        tick_cnt_next = tick_cnt;
        bit_cnt_next  = bit_cnt;
        sr_next       = sr;
        pop           = 1'b0;
        frame_end     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tick && enabled && !fifo_empty) begin
                    pop           = 1'b1;
                    sr_next       = fifo_dout;
                    tick_cnt_next = '0;
                    bit_cnt_next  = '0;
                    state_next    = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    tick_cnt_next = '0;
                    state_next    = ST_DATA;
                end else if (tick) begin
                    tick_cnt_next = tick_cnt + TW'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    tick_cnt_next = '0;
                    sr_next       = sr >> 1;
                    bit_cnt_next  = bit_cnt + 3'd1;
                    if (bit_cnt == BIT_LAST) begin
                        state_next = ST_STOP;
                    end
                end else if (tick) begin
                    tick_cnt_next = tick_cnt + TW'(1);
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    tick_cnt_next = '0;
                    frame_end     = 1'b1;
                    state_next    = ST_IDLE;
                end else if (tick) begin
                    tick_cnt_next = tick_cnt + TW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the line register changes on the same edge as the FSM.
    always_comb begin
        tx_next   = 1'b1;
        busy_next = (state_next != ST_IDLE);
        done_next = frame_end;
        case (state_next)
            ST_START: tx_next = 1'b0;
            ST_DATA:  tx_next = sr_next[0];
            default:  tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a bench-side line receiver and a byte-queue model of the FIFO.
module tb_uart_tx;

    localparam int OS        = 16;
    localparam int DEPTH     = 4;
    localparam int TICK_CLK  = 8;
    localparam int BIT_CLK   = OS * TICK_CLK;
    localparam int FRAME_CLK = 10 * BIT_CLK;

    logic       clk;
    logic       rst_n;
    logic       tx_clk;
    logic       enabled;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pushes = 0;
    int starts = 0;
    int done_cnt = 0;
    int frame_errs = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int start_cyc[$];

    uart_tx #(
        .OVERSAMPLE (OS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_clk  (tx_clk),
        .enabled (enabled),
        .data    (data),
        .valid   (valid),
        .ready   (ready),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Strobe rises on the negedge following a posedge with cyc % TICK_CLK == 0, high for two clk.
    initial begin
        tx_clk = 1'b0;
        forever begin
            @(negedge clk);
            tx_clk = ((cyc % TICK_CLK) < 2);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && done === 1'b1) done_cnt++;
        end
    end

    // Receiver: every bit must hold its level for exactly BIT_CLK cycles from the falling start edge.
    initial begin : rx_mon
        logic [9:0] bits;
        logic       ref_bit;
        bit         ok;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                starts++;
                start_cyc.push_back(cyc);
                ok = 1;
                aborted = 0;
                bits = '0;
                ref_bit = 1'b0;
                for (int t = 0; t < FRAME_CLK; t++) begin
                    if (t > 0) @(negedge clk);
                    if (rst_n !== 1'b1) aborted = 1;
                    if (t % BIT_CLK == 0) begin
                        ref_bit = tx;
                        bits[t / BIT_CLK] = tx;
                    end else if (tx !== ref_bit) begin
                        ok = 0;
                    end
                end
                if (!aborted) begin
                    if (!ok || bits[0] !== 1'b0 || bits[9] !== 1'b1) frame_errs++;
                    rx_q.push_back(bits[8:1]);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    task automatic try_write(input logic [7:0] b, output bit acc);
        logic exp_rdy;
        @(negedge clk);
        #1;
        exp_rdy = ((pushes - starts) < DEPTH);
        checks++;
        if (ready !== exp_rdy) begin
            errors++;
            $display("FAIL ready_model: ready=%b required %b (queued %0d)", ready, exp_rdy, pushes - starts);
        end
        data  = b;
        valid = 1'b1;
        if (exp_rdy) begin
            exp_q.push_back(b);
            pushes++;
        end
        acc = exp_rdy;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b);
        bit acc;
        int tries;
        acc = 0;
        tries = 0;
        while (!acc && tries < 3 * FRAME_CLK) begin
            try_write(b, acc);
            tries++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL write_timeout: byte %02h not accepted, required acceptance", b);
        end
    endtask

    task automatic drain(input string name);
        int n;
        int waited;
        logic [7:0] got;
        logic [7:0] want;
        n = exp_q.size();
        waited = 0;
        while (rx_q.size() < n && waited < (n + 1) * FRAME_CLK + 2000) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checks++;
        if (rx_q.size() < n) begin
            errors++;
            $display("FAIL %s_count: received %0d frames, required %0d", name, rx_q.size(), n);
        end
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s_byte: received %02h, required %02h", name, got, want);
            end
        end
        checks++;
        if (frame_errs != 0) begin
            errors++;
            $display("FAIL %s_framing: %0d malformed frames, required 0", name, frame_errs);
            frame_errs = 0;
        end
    endtask

    task automatic align_tick_cycle();
        do begin
            @(negedge clk);
        end while (cyc % TICK_CLK != 3);
        #1;
    endtask

    task automatic test_reset();
        int waited;
        @(negedge clk);
        #1;
        checks += 4;
        if (tx !== 1'b1)    begin errors++; $display("FAIL reset_tx: tx=%b required 1", tx); end
        if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: busy=%b required 0", busy); end
        if (done !== 1'b0)  begin errors++; $display("FAIL reset_done: done=%b required 0", done); end
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: ready=%b required 1", ready); end
        rst_n = 1'b1;
        enabled = 1'b1;
        write_byte(8'h00);
        for (int i = 1; i <= DEPTH; i++) write_byte(8'(i * 17));
        waited = 0;
        while (starts < 1 && waited < 2 * FRAME_CLK) begin
            @(negedge clk);
            waited++;
        end
        repeat (3 * BIT_CLK) @(negedge clk);
        #1;
        checks += 3;
        if (tx !== 1'b0)    begin errors++; $display("FAIL midframe_tx: tx=%b required 0", tx); end
        if (busy !== 1'b1)  begin errors++; $display("FAIL midframe_busy: busy=%b required 1", busy); end
        if (ready !== 1'b0) begin errors++; $display("FAIL midframe_full: ready=%b required 0", ready); end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (tx !== 1'b1)    begin errors++; $display("FAIL async_tx: tx=%b required 1", tx); end
        if (busy !== 1'b0)  begin errors++; $display("FAIL async_busy: busy=%b required 0", busy); end
        if (ready !== 1'b1) begin errors++; $display("FAIL async_ready: ready=%b required 1", ready); end
        exp_q.delete();
        pushes = 0;
        starts = 0;
        start_cyc.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (FRAME_CLK + 200) @(negedge clk);
        #1;
        checks += 3;
        if (starts != 0)       begin errors++; $display("FAIL reset_flush: %0d frames after reset, required 0", starts); end
        if (rx_q.size() != 0)  begin errors++; $display("FAIL reset_rx: %0d bytes after reset, required 0", rx_q.size()); end
        if (tx !== 1'b1)       begin errors++; $display("FAIL reset_idle_tx: tx=%b required 1", tx); end
        rx_q.delete();
        frame_errs = 0;
    endtask

    task automatic test_single();
        int base;
        base = done_cnt;
        enabled = 1'b1;
        write_byte(8'h73);
        drain("single");
        @(negedge clk);
        #1;
        checks += 2;
        if (done !== 1'b1) begin errors++; $display("FAIL single_done: done=%b required 1", done); end
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: busy=%b required 0", busy); end
        @(negedge clk);
        #1;
        checks += 2;
        if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: done=%b required 0", done); end
        if (done_cnt - base != 1) begin errors++; $display("FAIL single_done_count: %0d pulses, required 1", done_cnt - base); end
    endtask

    task automatic test_back_to_back();
        int base;
        int waited;
        int run;
        int max_run;
        logic [7:0] pat [4];
        pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'hA5; pat[3] = 8'h5A;
        base = done_cnt;
        start_cyc.delete();
        enabled = 1'b1;
        for (int i = 0; i < 4; i++) write_byte(pat[i]);
        waited = 0;
        while (busy !== 1'b1 && waited < 4 * TICK_CLK) begin
            @(negedge clk);
            #1;
            waited++;
        end
        run = 0;
        max_run = 0;
        waited = 0;
        while (done_cnt - base < 4 && waited < 6 * FRAME_CLK) begin
            @(negedge clk);
            #1;
            waited++;
            if (done_cnt - base >= 4) break;
            if (busy !== 1'b1) run++;
            else begin
                if (run > max_run) max_run = run;
                run = 0;
            end
        end
        drain("b2b");
        checks += 2;
        if (done_cnt - base != 4) begin errors++; $display("FAIL b2b_done_count: %0d pulses, required 4", done_cnt - base); end
        if (max_run > TICK_CLK)   begin errors++; $display("FAIL b2b_busy_gap: idle %0d clk, required at most %0d", max_run, TICK_CLK); end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (start_cyc.size() <= i || start_cyc[i] - start_cyc[i-1] != FRAME_CLK + TICK_CLK) begin
                errors++;
                $display("FAIL b2b_spacing: frame %0d start delta %0d, required %0d", i,
                         (start_cyc.size() > i) ? start_cyc[i] - start_cyc[i-1] : -1, FRAME_CLK + TICK_CLK);
            end
        end
    endtask

    task automatic test_full_fifo();
        bit acc;
        enabled = 1'b0;
        for (int i = 1; i <= 5; i++) try_write(8'(i), acc);
        @(negedge clk);
        #1;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL full_ready: ready=%b required 0", ready); end
        enabled = 1'b1;
        drain("full");
        repeat (FRAME_CLK + 200) @(negedge clk);
        checks++;
        if (rx_q.size() != 0) begin errors++; $display("FAIL full_overflow: %0d extra bytes, required 0", rx_q.size()); rx_q.delete(); end
    endtask

    task automatic test_enable_gating();
        int s0;
        int waited;
        bit stayed_high;
        logic [7:0] got;
        enabled = 1'b1;
        s0 = starts;
        write_byte(8'h3C);
        write_byte(8'h3D);
        waited = 0;
        while (starts == s0 && waited < 2 * FRAME_CLK) begin
            @(negedge clk);
            waited++;
        end
        repeat (4 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
        #1;
        enabled = 1'b0;
        waited = 0;
        while (rx_q.size() < 1 && waited < 2 * FRAME_CLK) begin
            @(negedge clk);
            #1;
            waited++;
        end
        got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
        void'(exp_q.pop_front());
        checks++;
        if (got !== 8'h3C) begin errors++; $display("FAIL gate_first: received %02h, required 3c", got); end
        stayed_high = 1;
        repeat (5 * BIT_CLK) begin
            @(negedge clk);
            if (tx !== 1'b1) stayed_high = 0;
        end
        checks += 2;
        if (!stayed_high)     begin errors++; $display("FAIL gate_hold_tx: tx left idle while disabled, required 1"); end
        if (starts != s0 + 1) begin errors++; $display("FAIL gate_hold_start: %0d frames started, required 1", starts - s0); end
        align_tick_cycle();
        enabled = 1'b1;
        @(negedge clk);
        #1;
        checks += 2;
        if (tx !== 1'b0) begin errors++; $display("FAIL gate_resume_tx: tx=%b required 0", tx); end
        if (start_cyc.size() == 0 || start_cyc[$] != cyc) begin
            errors++;
            $display("FAIL gate_resume_cycle: start at %0d, required %0d",
                     (start_cyc.size() > 0) ? start_cyc[$] : -1, cyc);
        end
        drain("gate");
    endtask

    task automatic test_simultaneous();
        logic [7:0] b [6];
        for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
        enabled = 1'b0;
        for (int i = 0; i < 3; i++) write_byte(b[i]);
        align_tick_cycle();
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL simul_pre_ready: ready=%b required 1", ready); end
        enabled = 1'b1;
        data = b[3];
        valid = 1'b1;
        exp_q.push_back(b[3]);
        pushes++;
        @(posedge clk);
        #1;
        valid = 1'b0;
        @(negedge clk);
        #1;
        checks += 3;
        if (tx !== 1'b0)    begin errors++; $display("FAIL simul_start_tx: tx=%b required 0", tx); end
        if (ready !== 1'b1) begin errors++; $display("FAIL simul_count: ready=%b required 1", ready); end
        if (busy !== 1'b1)  begin errors++; $display("FAIL simul_busy: busy=%b required 1", busy); end
        write_byte(b[4]);
        write_byte(b[5]);
        drain("simul");
    endtask

    task automatic test_random();
        enabled = 1'b1;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 600)) @(negedge clk);
            write_byte(8'($urandom));
        end
        drain("random");
    endtask

    initial begin
        rst_n   = 1'b0;
        enabled = 1'b0;
        data    = '0;
        valid   = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_full_fifo();
        test_enable_gating();
        test_simultaneous();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
